regex_pc_dispatcher: RTL and testbench

// - Thread-queue stage between regex_cpu_pipelined output and input. Buffers {cc_id, pc} pairs produced
//   by executed instructions (one per SPLIT branch / JMP / match-advance) and replays them to the CPU.
// - Merges external seed pcs (new string start per character context). Tracks outstanding threads per
//   cc_id, so the controller knows when a character context has fully drained.

---
 rtl/regex_pc_dispatcher_pkg.sv | 14 +
 rtl/regex_pc_fifo.sv | 63 ++++++
 rtl/regex_pc_dispatcher.sv | 127 ++++++++++++
 tb/tb_regex_pc_dispatcher.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regex_pc_dispatcher_pkg.sv
// Shared types and default widths for the regex thread dispatcher.
// Queue entries pack the character-context id above the program counter.
package regex_pc_dispatcher_pkg;

    localparam int DEF_PC_WIDTH    = 9;
    localparam int DEF_CC_ID_BITS  = 2;
    localparam int DEF_FIFO_W      = 3;

    typedef struct packed {
        logic [DEF_CC_ID_BITS-1:0] cc_id;
        logic [DEF_PC_WIDTH-1:0]   pc;
    } pc_entry_t;

endpackage

// File: rtl/regex_pc_fifo.sv
// Generic synchronous FIFO with register-array storage and asynchronous head read.
// Pushes while full and pops while empty are ignored.
module regex_pc_fifo #(
    parameter int WIDTH      = 11,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_occupancy
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full      = (r_count == FULL_COUNT);
    assign o_empty     = (r_count == '0);
    assign o_occupancy = r_count;
    assign o_head      = r_mem[r_rd_ptr];

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regex_pc_dispatcher.sv
// Thread queue between CPU output and input: merges CPU-produced pcs with external seeds,
// replays them in FIFO order and tracks outstanding threads per character context.
module regex_pc_dispatcher
    import regex_pc_dispatcher_pkg::*;
#(
    parameter int PC_WIDTH              = DEF_PC_WIDTH,
    parameter int CC_ID_BITS            = DEF_CC_ID_BITS,
    parameter int FIFO_WIDTH_POWER_OF_2 = DEF_FIFO_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_pc_valid,
    input  logic [PC_WIDTH-1:0]              in_pc,
    input  logic [CC_ID_BITS-1:0]            in_cc_id,
    output logic                             in_pc_ready,
    input  logic                             seed_valid,
    input  logic [PC_WIDTH-1:0]              seed_pc,
    input  logic [CC_ID_BITS-1:0]            seed_cc_id,
    output logic                             seed_ready,
    output logic                             out_pc_valid,
    output logic [PC_WIDTH-1:0]              out_pc,
    output logic [CC_ID_BITS-1:0]            out_cc_id,
    input  logic                             out_pc_ready,
    input  logic [2**CC_ID_BITS-1:0]         cpu_elaborating,
    output logic [2**CC_ID_BITS-1:0]         cc_pending,
    output logic [2**CC_ID_BITS-1:0]         cc_drained,
    output logic [FIFO_WIDTH_POWER_OF_2:0]   occupancy
);

    localparam int NUM_CC  = 2**CC_ID_BITS;
    localparam int ENTRY_W = CC_ID_BITS + PC_WIDTH;
    localparam int FIFO_W  = FIFO_WIDTH_POWER_OF_2;

    logic                                r_live;
    logic [NUM_CC-1:0][FIFO_W:0]         r_cc_count;

    logic                                w_full;
    logic                                w_empty;
    logic [FIFO_W:0]                     w_occ;
    logic [ENTRY_W-1:0]                  w_head;
    logic                                w_push_cpu;
    logic                                w_push_seed;
    logic                                w_push;
    logic [ENTRY_W-1:0]                  w_push_entry;
    logic [CC_ID_BITS-1:0]               w_push_cc;
    logic                                w_pop;
    logic [CC_ID_BITS-1:0]               w_pop_cc;
    logic [NUM_CC-1:0]                   w_inc;
    logic [NUM_CC-1:0]                   w_dec;

    // Held low through reset so neither producer sees ready until the first clock after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign in_pc_ready = r_live & ~w_full;
    assign seed_ready  = r_live & ~w_full & ~in_pc_valid;

    assign w_push_cpu   = in_pc_valid & in_pc_ready;
    assign w_push_seed  = seed_valid & seed_ready;
    assign w_push       = w_push_cpu | w_push_seed;
    assign w_push_cc    = w_push_cpu ? in_cc_id : seed_cc_id;
    assign w_push_entry = w_push_cpu ? {in_cc_id, in_pc} : {seed_cc_id, seed_pc};

    regex_pc_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_occupancy (w_occ)
    );

    assign out_pc_valid = ~w_empty;
    assign out_pc       = w_empty ? '0 : w_head[PC_WIDTH-1:0];
    assign out_cc_id    = w_empty ? '0 : w_head[ENTRY_W-1:PC_WIDTH];
    assign occupancy    = w_occ;

    assign w_pop    = out_pc_valid & out_pc_ready;
    assign w_pop_cc = w_head[ENTRY_W-1:PC_WIDTH];

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_push) begin
            w_inc[w_push_cc] = 1'b1;
        end
        if (w_pop) begin
            w_dec[w_pop_cc] = 1'b1;
        end
    end

    // A push and pop of the same context in one cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cc_count <= '0;
        end else begin
            for (int c = 0; c < NUM_CC; c++) begin
                if (w_inc[c] & ~w_dec[c]) begin
                    r_cc_count[c] <= r_cc_count[c] + 1'b1;
                end else if (w_dec[c] & ~w_inc[c]) begin
                    r_cc_count[c] <= r_cc_count[c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        cc_pending = '0;
        for (int c = 0; c < NUM_CC; c++) begin
            cc_pending[c] = |r_cc_count[c];
        end
    end

    assign cc_drained = ~cc_pending & ~cpu_elaborating;

endmodule

// File: tb/tb_regex_pc_dispatcher.sv
// Randomized self-checking bench for regex_pc_dispatcher against a queue-based thread model.
module tb_regex_pc_dispatcher;
    import regex_pc_dispatcher_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_pc_valid = 1'b0;
    logic [8:0] in_pc = '0;
    logic [1:0] in_cc_id = '0;
    logic       in_pc_ready;
    logic       seed_valid = 1'b0;
    logic [8:0] seed_pc = '0;
    logic [1:0] seed_cc_id = '0;
    logic       seed_ready;
    logic       out_pc_valid;
    logic [8:0] out_pc;
    logic [1:0] out_cc_id;
    logic       out_pc_ready = 1'b0;
    logic [3:0] cpu_elaborating = '0;
    logic [3:0] cc_pending;
    logic [3:0] cc_drained;
    logic [3:0] occupancy;

    int errors = 0;
    int checks = 0;

    pc_entry_t mq[$];
    bit        m_live = 1'b0;

    regex_pc_dispatcher dut (
        .clk             (clk),
        .rst             (rst),
        .in_pc_valid     (in_pc_valid),
        .in_pc           (in_pc),
        .in_cc_id        (in_cc_id),
        .in_pc_ready     (in_pc_ready),
        .seed_valid      (seed_valid),
        .seed_pc         (seed_pc),
        .seed_cc_id      (seed_cc_id),
        .seed_ready      (seed_ready),
        .out_pc_valid    (out_pc_valid),
        .out_pc          (out_pc),
        .out_cc_id       (out_cc_id),
        .out_pc_ready    (out_pc_ready),
        .cpu_elaborating (cpu_elaborating),
        .cc_pending      (cc_pending),
        .cc_drained      (cc_drained),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_pending();
        logic [3:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].cc_id] = 1'b1;
        return p;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit full;
        bit push_cpu;
        bit push_seed;
        bit pop;
        pc_entry_t e;
        full      = (mq.size() == DEPTH);
        push_cpu  = m_live && in_pc_valid && !full;
        push_seed = m_live && seed_valid && !in_pc_valid && !full;
        pop       = (mq.size() != 0) && out_pc_ready;
        if (push_cpu) begin
            e.cc_id = in_cc_id; e.pc = in_pc;
        end else begin
            e.cc_id = seed_cc_id; e.pc = seed_pc;
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push_cpu || push_seed) mq.push_back(e);
        m_live = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_pc_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_pc_valid); end
        checks++; if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_pc_ready); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL reset_seed_ready: got %b want 0", seed_ready); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (out_pc !== 9'h000 || out_cc_id !== 2'd0) begin errors++; $display("FAIL reset_out_data: got %h/%0d want 000/0", out_pc, out_cc_id); end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        checks++; if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_pc_ready); end
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL release_seed_ready: got %b want 1", seed_ready); end
    endtask

    task automatic test_seed();
        seed_valid = 1'b1; seed_pc = 9'h000; seed_cc_id = 2'd2;
        #1;
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL seed_ready: got %b want 1", seed_ready); end
        tick();
        seed_valid = 1'b0;
        #1;
        checks++; if (out_pc_valid !== 1'b1) begin errors++; $display("FAIL seed_out_valid: got %b want 1", out_pc_valid); end
        checks++; if (out_pc !== 9'h000 || out_cc_id !== 2'd2) begin errors++; $display("FAIL seed_out_data: got %h/%0d want 000/2", out_pc, out_cc_id); end
        checks++; if (cc_pending !== 4'b0100) begin errors++; $display("FAIL seed_pending: got %b want 0100", cc_pending); end
        out_pc_ready = 1'b1;
        tick();
        out_pc_ready = 1'b0;
        #1;
        checks++; if (out_pc_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL seed_pop: got valid=%b occ=%0d want 0/0", out_pc_valid, occupancy); end
        checks++; if (cc_drained !== 4'hF) begin errors++; $display("FAIL seed_drained: got %b want 1111", cc_drained); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            in_pc_valid = 1'b1; in_pc = 9'(9'h0F5 + i); in_cc_id = 2'd1;
            #1;
            checks++; if (in_pc_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_pc_ready); end
            tick();
        end
        in_pc_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL fill_occupancy: got %0d want 8", occupancy); end
        checks++; if (in_pc_ready !== 1'b0 || seed_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b/%b want 0/0", in_pc_ready, seed_ready); end
        checks++; if (cc_pending !== 4'b0010) begin errors++; $display("FAIL fill_pending: got %b want 0010", cc_pending); end
        in_pc_valid = 1'b1; in_pc = 9'h1FF; out_pc_ready = 1'b1;
        #1;
        checks++; if (in_pc_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", in_pc_ready); end
        checks++; if (out_pc !== 9'h0F5) begin errors++; $display("FAIL fill_head: got %h want 0f5", out_pc); end
        tick();
        in_pc_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_no_reuse: got %0d want 7", occupancy); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (out_pc !== 9'(9'h0F5 + i) || out_cc_id !== 2'd1 || out_pc_valid !== 1'b1) begin
                errors++; $display("FAIL fill_order_%0d: got %h/%0d want %h/1", i, out_pc, out_cc_id, 9'(9'h0F5 + i));
            end
            tick();
        end
        out_pc_ready = 1'b0;
        #1;
        checks++; if (out_pc_valid !== 1'b0 || occupancy !== 4'd0) begin errors++; $display("FAIL fill_empty: got valid=%b occ=%0d want 0/0", out_pc_valid, occupancy); end
    endtask

    task automatic test_priority();
        in_pc_valid = 1'b1; in_pc = 9'h055; in_cc_id = 2'd0;
        seed_valid = 1'b1; seed_pc = 9'h1AA; seed_cc_id = 2'd3;
        #1;
        checks++; if (seed_ready !== 1'b0 || in_pc_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got seed=%b cpu=%b want 0/1", seed_ready, in_pc_ready); end
        tick();
        in_pc_valid = 1'b0;
        #1;
        checks++; if (seed_ready !== 1'b1 || occupancy !== 4'd1 || out_pc !== 9'h055) begin
            errors++; $display("FAIL prio_first: got seed_ready=%b occ=%0d pc=%h want 1/1/055", seed_ready, occupancy, out_pc);
        end
        tick();
        seed_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL prio_occ: got %0d want 2", occupancy); end
        out_pc_ready = 1'b1;
        #1;
        checks++; if (out_pc !== 9'h055 || out_cc_id !== 2'd0) begin errors++; $display("FAIL prio_head0: got %h/%0d want 055/0", out_pc, out_cc_id); end
        tick();
        checks++; if (out_pc !== 9'h1AA || out_cc_id !== 2'd3) begin errors++; $display("FAIL prio_head1: got %h/%0d want 1aa/3", out_pc, out_cc_id); end
        tick();
        out_pc_ready = 1'b0;
    endtask

    task automatic test_split();
        cpu_elaborating = 4'b1000;
        in_pc_valid = 1'b1; in_pc = 9'h10A; in_cc_id = 2'd3;
        tick();
        in_pc = 9'h040;
        tick();
        in_pc_valid = 1'b0;
        #1;
        checks++; if (cc_pending !== 4'b1000 || cc_drained[3] !== 1'b0) begin errors++; $display("FAIL split_pending: got %b drained3=%b want 1000/0", cc_pending, cc_drained[3]); end
        out_pc_ready = 1'b1;
        checks++; if (out_pc !== 9'h10A || out_cc_id !== 2'd3) begin errors++; $display("FAIL split_first: got %h/%0d want 10a/3", out_pc, out_cc_id); end
        tick();
        checks++; if (out_pc !== 9'h040 || out_cc_id !== 2'd3 || cc_drained[3] !== 1'b0) begin
            errors++; $display("FAIL split_second: got %h/%0d drained3=%b want 040/3/0", out_pc, out_cc_id, cc_drained[3]);
        end
        tick();
        out_pc_ready = 1'b0;
        checks++; if (occupancy !== 4'd0 || cc_pending[3] !== 1'b0 || cc_drained[3] !== 1'b0) begin
            errors++; $display("FAIL split_elab: got occ=%0d pend3=%b drained3=%b want 0/0/0", occupancy, cc_pending[3], cc_drained[3]);
        end
        cpu_elaborating = 4'b0000;
        #1;
        checks++; if (cc_drained[3] !== 1'b1) begin errors++; $display("FAIL split_drained: got %b want 1", cc_drained[3]); end
    endtask

    task automatic test_steady();
        int sum;
        out_pc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seed_valid = 1'b1; seed_pc = 9'($urandom); seed_cc_id = 2'($urandom);
            tick();
        end
        seed_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            in_pc_valid = 1'b1; in_pc = 9'($urandom); in_cc_id = 2'($urandom);
            seed_valid = 1'($urandom); seed_pc = 9'($urandom);
            out_pc_ready = 1'b1;
            #1;
            sum = 0;
            for (int c = 0; c < 4; c++) sum += int'(dut.r_cc_count[c]);
            checks++; if (occupancy !== 4'd4 || out_pc !== mq[0].pc || out_cc_id !== mq[0].cc_id || sum != 4) begin
                errors++; $display("FAIL steady_%0d: got occ=%0d pc=%h cc=%0d sum=%0d want 4/%h/%0d/4", n, occupancy, out_pc, out_cc_id, sum, mq[0].pc, mq[0].cc_id);
            end
            tick();
        end
        in_pc_valid = 1'b0; seed_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [26:0] got;
        logic [26:0] exp;
        logic [3:0]  pend;
        int sum;
        for (int n = 0; n < 300; n++) begin
            in_pc_valid = ($urandom_range(0, 99) < 45); in_pc = 9'($urandom); in_cc_id = 2'($urandom);
            seed_valid = ($urandom_range(0, 99) < 40); seed_pc = 9'($urandom); seed_cc_id = 2'($urandom);
            out_pc_ready = ($urandom_range(0, 99) < 45);
            cpu_elaborating = 4'($urandom);
            #1;
            pend = model_pending();
            exp = {(mq.size() != 0),
                   (mq.size() != 0) ? mq[0].pc : 9'h000,
                   (mq.size() != 0) ? mq[0].cc_id : 2'd0,
                   4'(mq.size()), pend, ~pend & ~cpu_elaborating,
                   (mq.size() != DEPTH), (mq.size() != DEPTH) && !in_pc_valid};
            got = {out_pc_valid, out_pc, out_cc_id, occupancy, cc_pending, cc_drained, in_pc_ready, seed_ready};
            sum = 0;
            for (int c = 0; c < 4; c++) sum += int'(dut.r_cc_count[c]);
            checks++; if (got !== exp || sum != mq.size()) begin
                errors++; $display("FAIL random_%0d: got %h sum=%0d want %h sum=%0d", n, got, sum, exp, mq.size());
            end
            tick();
        end
        in_pc_valid = 1'b0; seed_valid = 1'b0; out_pc_ready = 1'b0; cpu_elaborating = '0;
    endtask

    task automatic test_reset_mid();
        while (mq.size() != 0) begin
            out_pc_ready = 1'b1;
            tick();
        end
        out_pc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_pc_valid = 1'b1; in_pc = 9'($urandom); in_cc_id = 2'($urandom);
            tick();
        end
        in_pc_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL mid_prefill: got %0d want 5", occupancy); end
        #1;
        rst = 1'b0;
        mq.delete();
        m_live = 1'b0;
        #1;
        checks++; if (out_pc_valid !== 1'b0 || occupancy !== 4'd0 || cc_pending !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: got valid=%b occ=%0d pend=%b want 0/0/0000", out_pc_valid, occupancy, cc_pending);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        checks++; if (in_pc_ready !== 1'b1 || occupancy !== 4'd0) begin errors++; $display("FAIL mid_release: got ready=%b occ=%0d want 1/0", in_pc_ready, occupancy); end
        seed_valid = 1'b1; seed_pc = 9'h123; seed_cc_id = 2'd1;
        tick();
        seed_valid = 1'b0;
        #1;
        checks++; if (out_pc_valid !== 1'b1 || out_pc !== 9'h123 || out_cc_id !== 2'd1) begin
            errors++; $display("FAIL mid_resume: got %b/%h/%0d want 1/123/1", out_pc_valid, out_pc, out_cc_id);
        end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_fill();
        test_priority();
        test_split();
        test_steady();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
